// File: rtl/dls_pkg.sv
// Shared types, constants and saturation helpers for the damped-least-squares update.
// The optional step clamp is enabled by defining DLS_STEP_CLAMP_EN.
package dls_pkg;

    localparam int N        = 6;
    localparam int W        = 36;
    localparam int FRAC     = 18;
    localparam int MULT_LAT = 1;
    localparam int AW       = 2 * W + 3;
    localparam int KW       = (N > 1) ? $clog2(N) : 1;
    localparam int DW       = $clog2(MULT_LAT + 1);

    typedef logic signed [W-1:0]   word_t;
    typedef logic signed [2*W-1:0] mul_t;
    typedef logic signed [AW-1:0]  acc_t;
    typedef word_t vec_t [N];
    typedef word_t mat_t [N][N];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC1,
        S_DRAIN1,
        S_MAC2,
        S_DRAIN2,
        S_DONE
    } state_t;

    localparam word_t ONE      = word_t'(1) <<< FRAC;
    localparam word_t MAX_STEP = 36'sd52429;
    localparam word_t WORD_MAX = word_t'({1'b0, {(W-1){1'b1}}});
    localparam word_t WORD_MIN = word_t'({1'b1, {(W-1){1'b0}}});

    // Rescale an accumulator back to word format, saturating on overflow.
    function automatic word_t sat_word(input acc_t a);
        acc_t  s;
        word_t r;
        s = a >>> FRAC;
        if (s > acc_t'(WORD_MAX)) begin
            r = WORD_MAX;
        end else if (s < acc_t'(WORD_MIN)) begin
            r = WORD_MIN;
        end else begin
            r = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic sat_ovf(input acc_t a);
        acc_t s;
        s = a >>> FRAC;
        return (s > acc_t'(WORD_MAX)) || (s < acc_t'(WORD_MIN));
    endfunction

endpackage

// File: rtl/dls_update_mac_lane.sv
// One multiply-accumulate lane: MULT_LAT-deep registered multiplier feeding a wide accumulator.
// A valid bit travels with each product so only issued operands are accumulated.
module mac_lane
    import dls_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  en_i,
    input  word_t a_i,
    input  word_t b_i,
    output acc_t  acc_o
);

    mul_t                prod_q [MULT_LAT];
    logic [MULT_LAT-1:0] vld_q;
    acc_t                acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
            acc_q <= '0;
        end else begin
            prod_q[0] <= mul_t'(a_i) * mul_t'(b_i);
            vld_q[0]  <= en_i & ~clr_i;
            for (int i = 1; i < MULT_LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1] & ~clr_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (vld_q[MULT_LAT-1]) begin
                acc_q <= acc_q + acc_t'(prod_q[MULT_LAT-1]);
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dls_update.sv
// Damped-least-squares joint step dtheta = J^T * (A^-1 * e) on N shared MAC lanes, two passes.
// Define DLS_STEP_CLAMP_EN to clamp each output element to +/-MAX_STEP after saturation.
module dls_update
    import dls_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  mat_t jacobian,
    input  mat_t inverse,
    input  vec_t error,
    output logic busy,
    output logic done,
    output vec_t dtheta,
    output logic overflow
);

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [DW-1:0]   drn_q;
    mat_t            inv_q;
    mat_t            jac_q;
    vec_t            e_q;
    vec_t            w_q;
    vec_t            dth_q;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;

    word_t           op_a [N];
    word_t           op_b [N];
    acc_t            lane_acc [N];
    vec_t            w_d;
    vec_t            dth_d;
    logic [N-1:0]    lane_ovf;

    logic            k_last;
    logic            drain_last;
    logic            lane_clr;
    logic            lane_en;

    assign k_last     = (k_q == KW'(N - 1));
    assign drain_last = ((state_q == S_DRAIN1) || (state_q == S_DRAIN2)) && (drn_q == DW'(MULT_LAT));
    assign lane_clr   = (state_q == S_LOAD) || drain_last;
    assign lane_en    = (state_q == S_MAC1) || (state_q == S_MAC2);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            // Second pass walks a column of J per lane, so the transpose is just an index swap.
            assign op_a[gi] = (state_q == S_MAC2) ? jac_q[k_q][gi] : inv_q[gi][k_q];
            assign op_b[gi] = (state_q == S_MAC2) ? w_q[k_q] : e_q[k_q];

            mac_lane u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr_i (lane_clr),
                .en_i  (lane_en),
                .a_i   (op_a[gi]),
                .b_i   (op_b[gi]),
                .acc_o (lane_acc[gi])
            );

            assign w_d[gi]      = sat_word(lane_acc[gi]);
            assign lane_ovf[gi] = sat_ovf(lane_acc[gi]);

`ifdef DLS_STEP_CLAMP_EN
            assign dth_d[gi] = (w_d[gi] > MAX_STEP)  ? MAX_STEP :
                               (w_d[gi] < -MAX_STEP) ? -MAX_STEP : w_d[gi];
`else
            assign dth_d[gi] = w_d[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            drn_q   <= '0;
            inv_q   <= '{default: '0};
            jac_q   <= '{default: '0};
            e_q     <= '{default: '0};
            w_q     <= '{default: '0};
            dth_q   <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Operands are captured on the accepting edge so callers may change them next cycle.
                    if (start) begin
                        state_q <= S_LOAD;
                        inv_q   <= inverse;
                        jac_q   <= jacobian;
                        e_q     <= error;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_q <= S_MAC1;
                    k_q     <= '0;
                end
                S_MAC1: begin
                    if (k_last) begin
                        state_q <= S_DRAIN1;
                        drn_q   <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DRAIN1: begin
                    if (drain_last) begin
                        state_q <= S_MAC2;
                        k_q     <= '0;
                        w_q     <= w_d;
                        if (|lane_ovf) ovf_q <= 1'b1;
                    end else begin
                        drn_q <= drn_q + DW'(1);
                    end
                end
                S_MAC2: begin
                    if (k_last) begin
                        state_q <= S_DRAIN2;
                        drn_q   <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DRAIN2: begin
                    if (drain_last) begin
                        state_q <= S_DONE;
                        dth_q   <= dth_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (|lane_ovf) ovf_q <= 1'b1;
                    end else begin
                        drn_q <= drn_q + DW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign dtheta   = dth_q;

endmodule

// File: tb/tb_dls_update.sv
// Randomized scoreboard bench for dls_update against a wide-integer reference model.
// Honours DLS_STEP_CLAMP_EN in both the model and the directed clamp case.
module tb_dls_update;
    import dls_pkg::*;

    typedef logic signed [127:0] big_t;
    localparam int LAT_CYC = 2 * (N + MULT_LAT + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    mat_t jac_v;
    mat_t inv_v;
    vec_t err_v;
    logic busy;
    logic done;
    vec_t dtheta;
    logic overflow;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [N*W-1:0] exp_dq [$];
    logic           exp_oq [$];
    int             exp_cq [$];

    dls_update dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .jacobian (jac_v),
        .inverse  (inv_v),
        .error    (err_v),
        .busy     (busy),
        .done     (done),
        .dtheta   (dtheta),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input vec_t v);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = v[i];
        return p;
    endfunction

    // Reference: dtheta = sat(J^T * sat(Ainv * e) / 2^FRAC) with exact floor division.
    function automatic void model(output logic [N*W-1:0] exp_v, output logic exp_o);
        big_t acc, d, hi, lo;
        big_t w [N];
        hi = (128'sd1 <<< (W - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (W - 1));
        exp_o = 1'b0;
        exp_v = '0;
        for (int r = 0; r < N; r++) begin
            acc = '0;
            for (int k = 0; k < N; k++) acc += big_t'(inv_v[r][k]) * big_t'(err_v[k]);
            d = acc >>> FRAC;
            if (d > hi) begin d = hi; exp_o = 1'b1; end
            else if (d < lo) begin d = lo; exp_o = 1'b1; end
            w[r] = d;
        end
        for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int k = 0; k < N; k++) acc += big_t'(jac_v[k][c]) * w[k];
            d = acc >>> FRAC;
            if (d > hi) begin d = hi; exp_o = 1'b1; end
            else if (d < lo) begin d = lo; exp_o = 1'b1; end
`ifdef DLS_STEP_CLAMP_EN
            if (d > big_t'(52429)) d = big_t'(52429);
            else if (d < -big_t'(52429)) d = -big_t'(52429);
`endif
            exp_v[c*W +: W] = d[W-1:0];
        end
    endfunction

    function automatic word_t rnd(input bit big);
        logic [63:0] t;
        int          v;
        if (big) begin
            t = {$urandom(), $urandom()};
            return t[W-1:0];
        end
        v = int'($urandom_range(0, 2097152)) - 1048576;
        return word_t'(v);
    endfunction

    task automatic rand_inputs(input bit big);
        for (int r = 0; r < N; r++) begin
            err_v[r] = rnd(big);
            for (int c = 0; c < N; c++) begin
                jac_v[r][c] = rnd(big);
                inv_v[r][c] = rnd(big);
            end
        end
    endtask

    task automatic set_diag(input word_t dj, input word_t di);
        for (int r = 0; r < N; r++) begin
            err_v[r] = '0;
            for (int c = 0; c < N; c++) begin
                jac_v[r][c] = (r == c) ? dj : '0;
                inv_v[r][c] = (r == c) ? di : '0;
            end
        end
    endtask

    // Called right after a negedge; start is seen by the following posedge.
    task automatic issue(input bit push);
        logic [N*W-1:0] ev;
        logic           eo;
        model(ev, eo);
        start = 1'b1;
        if (push) begin
            exp_dq.push_back(ev);
            exp_oq.push_back(eo);
            exp_cq.push_back(cyc + LAT_CYC + 1);
        end
        $display("[TB] start issued at cycle %0d", cyc);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ovf_cleared_on_start", overflow, 0);
        rand_inputs(1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (exp_cq.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain_timeout", exp_cq.size(), 0);
        exp_dq.delete();
        exp_oq.delete();
        exp_cq.delete();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_cq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                check("dtheta", pack(dtheta), exp_dq.pop_front());
                check("overflow", overflow, exp_oq.pop_front());
                check("latency", cyc, exp_cq.pop_front());
                $display("[TB] done at cycle %0d dtheta0=%0d ovf=%0b", cyc, dtheta[0], overflow);
            end
        end
    end

    initial begin
        int d0;
        rst   = 1'b0;
        start = 1'b0;
        set_diag('0, '0);
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", overflow, 0);
        check("reset_dtheta", pack(dtheta), '0);
        rst = 1'b1;
        @(negedge clk);

        // Identity: dtheta equals e.
        set_diag(ONE, ONE);
        for (int i = 0; i < N; i++) err_v[i] = word_t'(i + 1) * ONE;
        issue(1'b1);
        wait_idle();

        // Transposed read of J.
        set_diag('0, ONE);
        jac_v[0][1] = word_t'(524288);
        err_v[0]    = ONE;
        issue(1'b1);
        wait_idle();

        // Saturation, then overflow clears on the next start.
        set_diag(word_t'(1) <<< 34, word_t'(1) <<< 34);
        err_v[0] = word_t'(1) <<< 34;
        issue(1'b1);
        wait_idle();
        rand_inputs(1'b0);
        issue(1'b1);
        wait_idle();

        // Start while busy is ignored.
        d0 = done_cnt;
        rand_inputs(1'b0);
        issue(1'b1);
        repeat (3) @(negedge clk);
        rand_inputs(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("single_done", done_cnt - d0, 1);

        // Start in the DONE cycle is accepted.
        rand_inputs(1'b0);
        issue(1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("b2b_done_seen", done, 1);
        rand_inputs(1'b0);
        issue(1'b1);
        wait_idle();

        for (int t = 0; t < 12; t++) begin
            rand_inputs(t % 4 == 3);
            issue(1'b1);
            wait_idle();
        end

`ifdef DLS_STEP_CLAMP_EN
        set_diag(ONE, ONE);
        err_v[2] = ONE;
        err_v[3] = -ONE;
        issue(1'b1);
        wait_idle();
`endif

        // Reset mid-operation.
        set_diag(ONE, ONE);
        for (int i = 0; i < N; i++) err_v[i] = ONE;
        issue(1'b1);
        wait_idle();
        d0 = done_cnt;
        rand_inputs(1'b0);
        issue(1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_dtheta", pack(dtheta), '0);
        check("midreset_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        check("midreset_no_done", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
